// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// and STATUS register bit layout.
package irq_controller_pkg;

  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_PENDING = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;

  localparam int STAT_BUSY_BIT = 8;
  localparam int STAT_SIG_BIT  = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQUEST = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module irq_prio_enc #(
  parameter int N_IRQ = 8,
  parameter int ID_W  = 3
) (
  input  logic [N_IRQ-1:0] req_i,
  output logic             valid_o,
  output logic [ID_W-1:0]  id_o
);

  // Scan downwards so the lowest set index is the last one written.
  always_comb begin
    valid_o = 1'b0;
    id_o    = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        id_o    = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Interrupt source for the CPU: edge-detects, masks and prioritises device
// requests, and runs the int_sig / int_ack / int_eoi handshake, one at a time.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter int          ID_W      = 3,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0080,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             int_sig,
  input  logic             int_ack,
  input  logic             int_eoi,
  output logic [31:0]      int_vector,
  output logic [ID_W-1:0]  int_id,
  output logic             int_busy,
  input  logic [1:0]       reg_addr,
  input  logic             reg_we,
  input  logic [31:0]      reg_wdata,
  output logic [31:0]      reg_rdata
);

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] pend_q, pend_d;
  logic [N_IRQ-1:0] prev_q;
  logic             sig_q, sig_d;
  logic             busy_q, busy_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      vec_q, vec_d;

  logic [N_IRQ-1:0] edge_det, w1c, ack_clr;
  logic             win_vld, take_ack;
  logic [ID_W-1:0]  win_id;

  irq_prio_enc #(.N_IRQ(N_IRQ), .ID_W(ID_W)) u_prio (
    .req_i   (pend_q & mask_q),
    .valid_o (win_vld),
    .id_o    (win_id)
  );

  assign edge_det = irq_in & ~prev_q;
  assign w1c      = (reg_we && reg_addr == REG_PENDING) ? reg_wdata[N_IRQ-1:0] : '0;
  assign take_ack = (state_q == ST_REQUEST) && int_ack;

  always_comb begin
    ack_clr = '0;
    if (take_ack) ack_clr[id_q] = 1'b1;
  end

  // New edges are OR-ed in last so they win over both W1C and ack clearing.
  assign pend_d = (pend_q & ~w1c & ~ack_clr) | edge_det;
  assign mask_d = (reg_we && reg_addr == REG_MASK) ? reg_wdata[N_IRQ-1:0] : mask_q;

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    busy_d  = busy_q;
    id_d    = id_q;
    vec_d   = vec_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          id_d    = win_id;
          sig_d   = 1'b1;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (int_ack) begin
          vec_d   = VEC_BASE + (32'(id_q) << VEC_SHIFT);
          sig_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_SERVICE;
        end
      end
      ST_SERVICE: begin
        if (int_eoi) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      sig_q   <= 1'b0;
      busy_q  <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      prev_q  <= irq_in;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      REG_MASK:    reg_rdata[N_IRQ-1:0] = mask_q;
      REG_PENDING: reg_rdata[N_IRQ-1:0] = pend_q;
      REG_STATUS: begin
        reg_rdata[STAT_BUSY_BIT] = busy_q;
        reg_rdata[STAT_SIG_BIT]  = sig_q;
        reg_rdata[ID_W-1:0]      = id_q;
      end
      default: reg_rdata = '0;
    endcase
  end

  assign int_sig    = sig_q;
  assign int_busy   = busy_q;
  assign int_id     = id_q;
  assign int_vector = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed table-driven bench for irq_controller, plus a latency/handshake sequence.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_in;
  logic        int_sig, int_ack, int_eoi, int_busy, reg_we;
  logic [31:0] int_vector, reg_wdata, reg_rdata;
  logic [2:0]  int_id;
  logic [1:0]  reg_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(8), .ID_W(3), .VEC_BASE(32'h80), .VEC_SHIFT(4)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .int_sig(int_sig), .int_ack(int_ack),
    .int_eoi(int_eoi), .int_vector(int_vector), .int_id(int_id), .int_busy(int_busy),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        ack, eoi;
    logic        e_sig, e_busy;
    logic [2:0]  e_id;
    logic [31:0] e_vec, e_rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [7:0] i, logic w, logic [1:0] a, logic [31:0] d,
                              logic ak, logic eo, logic s, logic b, logic [2:0] id,
                              logic [31:0] v, logic [31:0] rd);
    vec_t t;
    t.rst = r; t.irq = i; t.we = w; t.addr = a; t.wdata = d; t.ack = ak; t.eoi = eo;
    t.e_sig = s; t.e_busy = b; t.e_id = id; t.e_vec = v; t.e_rd = rd;
    return t;
  endfunction

  task automatic chk(string name, int row, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; irq_in = '0; int_ack = 0; int_eoi = 0; reg_we = 0; reg_addr = 2'd1; reg_wdata = '0;

    //             rst irq   we a  wdata  ak eo  sig bsy id vec     rdata
    // reset, mask=FF, single edge on irq[3]
    tbl.push_back(mk(1, 8'h00, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 0
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'hFF, 0, 0,  0, 0, 0, 32'h80, 32'hFF));  // 1
    tbl.push_back(mk(0, 8'h08, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h08));  // 2
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 3, 32'h80, 32'h08));  // 3
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 3, 32'h80, 32'h08));  // 4
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 3, 32'hB0, 32'h00));  // 5
    tbl.push_back(mk(0, 8'h00, 0, 2, 32'h00, 0, 0,  0, 1, 3, 32'hB0, 32'h103)); // 6
    tbl.push_back(mk(0, 8'h00, 0, 2, 32'h00, 0, 1,  0, 0, 3, 32'hB0, 32'h003)); // 7
    // simultaneous edges on 5 and 1
    tbl.push_back(mk(0, 8'h22, 0, 1, 32'h00, 0, 0,  0, 0, 3, 32'hB0, 32'h22));  // 8
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 1, 32'hB0, 32'h22));  // 9
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 1, 32'h90, 32'h20));  // 10
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 1, 32'h90, 32'h20));  // 11
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 5, 32'h90, 32'h20));  // 12
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 5, 32'hD0, 32'h00));  // 13
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 5, 32'hD0, 32'h00));  // 14
    // masked edge, then unmask
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'h00, 0, 0,  0, 0, 5, 32'hD0, 32'h00));  // 15
    tbl.push_back(mk(0, 8'h04, 0, 1, 32'h00, 0, 0,  0, 0, 5, 32'hD0, 32'h04));  // 16
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  0, 0, 5, 32'hD0, 32'h04));  // 17
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'h04, 0, 0,  0, 0, 5, 32'hD0, 32'h04));  // 18
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 2, 32'hD0, 32'h04));  // 19
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 2, 32'hA0, 32'h00));  // 20
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 2, 32'hA0, 32'h00));  // 21
    // REQUEST id 4 frozen against mask clear and W1C
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'h10, 0, 0,  0, 0, 2, 32'hA0, 32'h10));  // 22
    tbl.push_back(mk(0, 8'h10, 0, 1, 32'h00, 0, 0,  0, 0, 2, 32'hA0, 32'h10));  // 23
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 4, 32'hA0, 32'h10));  // 24
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'h00, 0, 0,  1, 0, 4, 32'hA0, 32'h00));  // 25
    tbl.push_back(mk(0, 8'h00, 1, 1, 32'h10, 0, 0,  1, 0, 4, 32'hA0, 32'h00));  // 26
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 4, 32'hC0, 32'h00));  // 27
    // edge during SERVICE waits for eoi; stray eoi/ack ignored
    tbl.push_back(mk(0, 8'h00, 1, 0, 32'hFF, 0, 0,  0, 1, 4, 32'hC0, 32'hFF));  // 28
    tbl.push_back(mk(0, 8'h01, 0, 1, 32'h00, 0, 0,  0, 1, 4, 32'hC0, 32'h01));  // 29
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  0, 1, 4, 32'hC0, 32'h01));  // 30
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 4, 32'hC0, 32'h01));  // 31
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 0, 32'hC0, 32'h01));  // 32
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  1, 0, 0, 32'hC0, 32'h01));  // 33
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 0, 32'h80, 32'h00));  // 34
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 0, 32'h80, 32'h00));  // 35
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 0, 32'h80, 32'h00));  // 36
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 0, 0, 32'h80, 32'h00));  // 37
    // highest source, ack+eoi together
    tbl.push_back(mk(0, 8'h80, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h80));  // 38
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 7, 32'h80, 32'h80));  // 39
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 1,  0, 1, 7, 32'hF0, 32'h00));  // 40
    tbl.push_back(mk(0, 8'h00, 0, 2, 32'h00, 0, 0,  0, 1, 7, 32'hF0, 32'h107)); // 41
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 7, 32'hF0, 32'h00));  // 42
    // set beats W1C, set beats ack clear
    tbl.push_back(mk(0, 8'h02, 1, 1, 32'h02, 0, 0,  0, 0, 7, 32'hF0, 32'h02));  // 43
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 1, 32'hF0, 32'h02));  // 44
    tbl.push_back(mk(0, 8'h02, 0, 1, 32'h00, 1, 0,  0, 1, 1, 32'h90, 32'h02));  // 45
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 1,  0, 0, 1, 32'h90, 32'h02));  // 46
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 0, 0,  1, 0, 1, 32'h90, 32'h02));  // 47
    tbl.push_back(mk(0, 8'h00, 0, 1, 32'h00, 1, 0,  0, 1, 1, 32'h90, 32'h00));  // 48
    // reset during SERVICE with pending 22, then level held across reset
    tbl.push_back(mk(0, 8'h22, 0, 1, 32'h00, 0, 0,  0, 1, 1, 32'h90, 32'h22));  // 49
    tbl.push_back(mk(1, 8'h00, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 50
    tbl.push_back(mk(1, 8'h04, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 51
    tbl.push_back(mk(0, 8'h04, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h04));  // 52
    tbl.push_back(mk(0, 8'h04, 1, 1, 32'h04, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 53
    tbl.push_back(mk(0, 8'h04, 0, 1, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 54
    tbl.push_back(mk(0, 8'h04, 0, 3, 32'h00, 0, 0,  0, 0, 0, 32'h80, 32'h00));  // 55

    foreach (tbl[r]) begin
      @(negedge clk);
      rst = tbl[r].rst; irq_in = tbl[r].irq; reg_we = tbl[r].we; reg_addr = tbl[r].addr;
      reg_wdata = tbl[r].wdata; int_ack = tbl[r].ack; int_eoi = tbl[r].eoi;
      @(posedge clk); #1;
      chk("int_sig",    r, 32'(int_sig),  32'(tbl[r].e_sig));
      chk("int_busy",   r, 32'(int_busy), 32'(tbl[r].e_busy));
      chk("int_id",     r, 32'(int_id),   32'(tbl[r].e_id));
      chk("int_vector", r, int_vector,    tbl[r].e_vec);
      chk("reg_rdata",  r, reg_rdata,     tbl[r].e_rd);
    end

    // Latency sequence: unmask all, pulse irq[6] with irq[2] still held high.
    @(negedge clk);
    rst = 0; int_ack = 0; int_eoi = 0; reg_we = 1; reg_addr = 2'd0; reg_wdata = 32'hFF;
    @(negedge clk);
    reg_we = 0; reg_addr = 2'd1; irq_in = 8'h44;
    @(posedge clk); #1;
    chk("seq_sig_after_1", 100, 32'(int_sig), 32'd0);
    lat = 1;
    @(negedge clk);
    irq_in = 8'h04;
    while (!int_sig && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("seq_latency", 101, 32'(lat), 32'd2);
    chk("seq_id", 102, 32'(int_id), 32'd6);
    @(negedge clk); int_ack = 1;
    @(posedge clk); #1;
    chk("seq_vector", 103, int_vector, 32'hE0);
    chk("seq_busy", 104, 32'(int_busy), 32'd1);
    @(negedge clk); int_ack = 0; int_eoi = 1;
    @(posedge clk); #1;
    chk("seq_busy_eoi", 105, 32'(int_busy), 32'd0);
    @(negedge clk); int_eoi = 0;
    @(posedge clk); #1;
    chk("seq_no_rerequest", 106, 32'(int_sig), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt source side of the CPU interrupt handshake: drives `int_sig` into the control unit and supplies the handler vector for PC source 3.
- Collects N device request lines, edge-detects them, masks them and prioritises them.
- Tracks one in-service interrupt until the handler's RFE completes; nesting is not supported.
- Sits beside the datapath; mask/pending registers are accessed through a small register port from the memory-mapped I/O decoder.

Parameters:
N_IRQ, 8, number of request inputs (1..32)
ID_W, 3, width of source id; must satisfy 2**ID_W >= N_IRQ
VEC_BASE, 32'h0000_0080, handler vector for source 0
VEC_SHIFT, 4, vector stride exponent; vector = VEC_BASE + (id << VEC_SHIFT)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
irq_in  in  N_IRQ  device requests, already synchronous to clk, rising-edge significant
int_sig  out  1  interrupt request to control unit
int_ack  in  1  one-cycle ack from control unit (its int_save_pc strobe)
int_eoi  in  1  one-cycle end-of-interrupt (RFE executed, PC restored)
int_vector  out  32  handler address, stable from ack until eoi
int_id  out  ID_W  id of request/in-service source
int_busy  out  1  handler in service
reg_addr  in  2  0=MASK, 1=PENDING, 2=STATUS
reg_we  in  1  register write strobe
reg_wdata  in  32  write data
reg_rdata  out  32  combinational read data

Behaviour:
- Reset, applied synchronously on clk: state=IDLE, int_sig=0, int_busy=0, int_id=0, int_vector=VEC_BASE, mask=0, pending=0, irq_prev=0.
- irq_prev resets to 0, so a line already high at reset release registers one edge.
- Edge detect: edge = irq_in & ~irq_prev. The pending bit sets on the cycle after the edge. A level held high gives only one request.
- MASK register (rw, bits N_IRQ-1:0). PENDING register (read; write-1-to-clear). STATUS register: {busy[8], int_sig[7], id[ID_W-1:0]}. Unused bits read 0.
- If a pending bit sees a new edge and a W1C in the same cycle, set wins.
- Priority: lowest index among (pending & mask) wins.
- State machine, registered outputs:
  - IDLE: if (pending & mask) != 0, latch winner into int_id, go REQUEST, int_sig=1 the next cycle. Latency from irq_in edge to int_sig high is 2 cycles.
  - REQUEST: int_sig held high until int_ack.
    - int_id is frozen. Later mask writes or W1C do not change it, because the control unit latches the request sticky on the int_sig edge.
    - On int_ack: clear pending[int_id] (a coincident edge on that source wins), load int_vector = VEC_BASE + (int_id << VEC_SHIFT), set int_sig=0 and int_busy=1, go SERVICE. int_vector is valid the cycle after ack, which is when the control unit's INTERRUPT state selects PC source 3.
  - SERVICE: int_sig stays 0; new edges still accumulate in pending. On int_eoi: int_busy=0, go IDLE. A remaining enabled pending bit produces the next request 1 cycle later.
- int_ack outside REQUEST is ignored. int_eoi outside SERVICE is ignored.
- If int_ack and int_eoi arrive together in REQUEST, the ack is taken and the eoi is ignored.
- Vector arithmetic is modulo 2^32 and is not checked for overflow.
- Reset mid-operation returns to IDLE and drops every pending request, including the one in service.

Decomposition:
- Shared package/header holds:
  - register offsets (REG_MASK=0, REG_PENDING=1, REG_STATUS=2);
  - state encodings (IDLE, REQUEST, SERVICE);
  - STATUS bit positions.
- One natural sub-module: irq_prio_enc, a combinational lowest-index-first priority encoder, N_IRQ in, {valid, id} out.

Test Plan:
- mask=8'hFF; pulse irq_in[3] -> pending=8'h08; int_sig high 2 cycles after the edge; int_id=3. Ack -> int_vector=32'h0000_00B0, int_busy=1, pending=0, int_sig=0.
- Edges on irq[5] and irq[1] in the same cycle, mask=8'hFF -> id 1 served first with vector 32'h90. After eoi, id 5 is requested 1 cycle later with vector 32'hD0.
- mask=8'h00, edge on irq[2] -> pending=8'h04 and no int_sig. Write MASK=8'h04 -> int_sig rises the next cycle.
- In REQUEST for id 4, write MASK=0 and PENDING W1C 8'h10 -> int_sig stays high. Ack still delivers vector 32'hC0.
- In SERVICE, edge on irq[0] -> no int_sig until int_eoi. int_eoi pulsed in IDLE or REQUEST -> no state change.
- Assert rst during SERVICE with pending=8'h22 -> next cycle all outputs are at reset values and pending=0. irq held high across reset produces exactly one pending set.
